// File: rtl/debounced_bcd_updown.sv
// Two-button debounced N-digit BCD up/down counter
// with wrap pulses and hold-to-repeat.

module button_stage #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic step
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] T_DELAY =
    TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] T_PERIOD = TW'(REPEAT_PERIOD - 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY > 0);

  logic          s;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic          rise;
  logic          held;
  logic          rpt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s   <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      s <= raw;
      if (raw != s)
        cnt <= '0;
      else if (cnt == C_MAX)
        deb <= s;
      else
        cnt <= cnt + CW'(1);
    end
  end

  assign rise = deb & ~deb_q;
  assign held = deb & deb_q;
  assign rpt  = REPEAT_EN && held && (tmr == '0);
  assign step = rise | rpt;

  // Down-counter reaching zero marks the next repeat step.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q <= 1'b0;
      tmr   <= '0;
    end else begin
      deb_q <= deb;
      if (!deb)
        tmr <= '0;
      else if (rise)
        tmr <= T_DELAY;
      else if (rpt)
        tmr <= T_PERIOD;
      else if (tmr != '0)
        tmr <= tmr - TW'(1);
    end
  end
endmodule

module debounced_bcd_updown #(
  parameter int DIGITS          = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow,
  output logic                  underflow
);
  logic                up_step;
  logic                dn_step;
  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic                carry;
  logic                borrow;

  button_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_up (
    .clock(clock),
    .reset(reset),
    .raw  (btn_up),
    .step (up_step)
  );

  button_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dn (
    .clock(clock),
    .reset(reset),
    .raw  (btn_down),
    .step (dn_step)
  );

  // Carry/borrow surviving the last digit means all 9s / all 0s.
  always_comb begin
    inc_val = digits;
    dec_val = digits;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (digits[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = digits[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (digits[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = digits[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digits    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (clear) begin
        digits <= '0;
      end else if (up_step && !dn_step) begin
        digits   <= inc_val;
        overflow <= carry;
      end else if (dn_step && !up_step) begin
        digits    <= dec_val;
        underflow <= borrow;
      end
    end
  end
endmodule

// File: tb/tb_debounced_bcd_updown.sv
// Scoreboard bench: dut 0 without repeat, dut 1 with
// repeat delay 20 / period 5; debounce 4 on both.

module tb_debounced_bcd_updown;
  localparam int DB = 4;
  localparam int RD_B = 20;
  localparam int RP_B = 5;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       o;
    logic       u;
  } ev_t;

  logic       clk = 1'b0;
  logic       up_v [2];
  logic       dn_v [2];
  logic       clr_v[2];
  logic       rst_v[2];
  logic [7:0] dg   [2];
  logic       ov   [2];
  logic       un   [2];
  logic [7:0] prv  [2];

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  val[2];
  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounced_bcd_updown #(
    .DIGITS(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
  ) dut_a (
    .clock(clk), .reset(rst_v[0]),
    .btn_up(up_v[0]), .btn_down(dn_v[0]),
    .clear(clr_v[0]), .digits(dg[0]),
    .overflow(ov[0]), .underflow(un[0])
  );

  debounced_bcd_updown #(
    .DIGITS(2), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD_B), .REPEAT_PERIOD(RP_B)
  ) dut_b (
    .clock(clk), .reset(rst_v[1]),
    .btn_up(up_v[1]), .btn_down(dn_v[1]),
    .clear(clr_v[1]), .digits(dg[1]),
    .overflow(ov[1]), .underflow(un[1])
  );

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic void push(input int w, input int cy,
                               input int v, input bit o,
                               input bit u);
    ev_t e;
    e.cyc = cy;
    e.d = bcd(v);
    e.o = o;
    e.u = u;
    if (w == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  task automatic chk(input string nm, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h",
                  nm, got, exp);
  endtask

  task automatic mon(input int w);
    ev_t e;
    bit  have;
    have = 1'b0;
    if (w == 0 && q0.size() > 0) begin
      e = q0.pop_front();
      have = 1'b1;
    end
    if (w == 1 && q1.size() > 0) begin
      e = q1.pop_front();
      have = 1'b1;
    end
    n_chk++;
    if (!have)
      $display("FAIL unexpected_event dut%0d cyc %0d: got %h o%b u%b, required no change",
               w, cyc, dg[w], ov[w], un[w]);
    else if (e.cyc != cyc || e.d !== dg[w] ||
             e.o !== ov[w] || e.u !== un[w])
      $display("FAIL event dut%0d: got cyc %0d %h o%b u%b, required cyc %0d %h o%b u%b",
               w, cyc, dg[w], ov[w], un[w],
               e.cyc, e.d, e.o, e.u);
    else n_pass++;
  endtask

  initial begin
    prv[0] = 8'h00;
    prv[1] = 8'h00;
  end

  always @(negedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (dg[w] !== prv[w] || ov[w] !== 1'b0 ||
          un[w] !== 1'b0) begin
        mon(w);
        prv[w] = dg[w];
      end
    end
  end

  // Called right after a negedge; returns right after one.
  task automatic press(input int w, input bit up,
                       input bit dn, input int hold,
                       input int gap, input int clr_off,
                       input int rst_off);
    int c;
    int e0;
    int rd;
    int rp;
    bit st;
    bit su;
    bit sd;
    rd = (w == 0) ? 0 : RD_B;
    rp = (w == 0) ? 1 : RP_B;
    c  = cyc;
    e0 = DB + 3;
    up_v[w] = up;
    dn_v[w] = dn;
    for (int o = 1; o <= hold + gap; o++) begin
      if (o == rst_off + 1 || o == clr_off + 1) begin
        if (val[w] != 0) push(w, c + o, 0, 0, 0);
        val[w] = 0;
        if (o == rst_off + 1) e0 = o + DB + 3;
      end else begin
        st = (o == e0) ||
             (rd > 0 && o >= e0 + rd &&
              (o - e0 - rd) % rp == 0 &&
              o <= hold + DB + 2);
        su = up && st;
        sd = dn && st;
        if (su && !sd) begin
          if (val[w] == 99) begin
            val[w] = 0;
            push(w, c + o, 0, 1, 0);
          end else begin
            val[w]++;
            push(w, c + o, val[w], 0, 0);
          end
        end else if (sd && !su) begin
          if (val[w] == 0) begin
            val[w] = 99;
            push(w, c + o, 99, 0, 1);
          end else begin
            val[w]--;
            push(w, c + o, val[w], 0, 0);
          end
        end
      end
    end
    for (int i = 1; i <= hold + gap; i++) begin
      @(negedge clk);
      if (i >= hold) begin
        up_v[w] = 1'b0;
        dn_v[w] = 1'b0;
      end
      clr_v[w] = (i == clr_off);
      rst_v[w] = (i == rst_off);
    end
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      up_v[w]  = 1'b0;
      dn_v[w]  = 1'b0;
      clr_v[w] = 1'b0;
      rst_v[w] = 1'b1;
      val[w]   = 0;
    end
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("reset_digits", int'(dg[w]), 0);
      chk("reset_pulses", int'({ov[w], un[w]}), 0);
    end
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    @(negedge clk);

    press(0, 1, 0, 20, 8, -1, -1);
    press(0, 1, 0, 8, 8, -1, -1);
    for (int i = 0; i < 30; i++) begin
      up_v[0] = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    up_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 97; k++)
      press(0, 1, 0, 8, 8, -1, -1);
    press(0, 1, 0, 8, 8, -1, -1);
    press(0, 0, 1, 8, 8, -1, -1);
    press(0, 1, 1, 8, 8, -1, -1);
    press(0, 0, 0, 0, 6, 2, -1);
    press(0, 1, 0, 8, 8, 6, -1);
    press(0, 1, 0, 8, 8, -1, -1);

    press(1, 1, 0, 50, 8, -1, -1);
    press(1, 1, 1, 8, 8, -1, -1);
    press(1, 1, 0, 360, 8, 339, -1);
    press(1, 1, 0, 80, 8, -1, 68);

    repeat (20) @(negedge clk);
    chk("pending_a", q0.size(), 0);
    chk("pending_b", q1.size(), 0);
    chk("final_a", int'(dg[0]), int'(bcd(val[0])));
    chk("final_b", int'(dg[1]), int'(bcd(val[1])));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end
endmodule
